// File: rtl/seg_scan_driver.sv
// Multiplexed 4-digit 7-segment scan driver with inter-digit blanking,
// frame-aligned double buffering of the display payload, and per-digit blink.

package seg_scan_driver_pkg;
  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blink;
  } disp_s;
endpackage

module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 100000000,
  parameter int unsigned REFRESH_HZ   = 1000,
  parameter int unsigned BLANK_CYCLES = 64,
  parameter int unsigned BLINK_HZ     = 2
) (
  input  logic        src_clk,
  input  logic        src_rst,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_mask,
  input  logic [3:0]  blink_mask,
  input  logic        blink_en,
  input  logic        load,
  output logic [3:0]  an,
  output logic [7:0]  seg,
  output logic [1:0]  digit_sel,
  output logic        frame_done
);

  localparam int unsigned DIV   = CLK_HZ / REFRESH_HZ;
  localparam int unsigned HALF  = CLK_HZ / (2 * BLINK_HZ);
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BLK_W = (HALF > 1) ? $clog2(HALF) : 1;

  typedef enum logic {ST_BLANK, ST_SHOW} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
  logic             phase_q, phase_d;
  disp_s            shadow_q, shadow_d;
  disp_s            active_q, active_d;
  logic             pending_q, pending_d;
  logic [3:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;
  logic [1:0]       sel_out_q;
  logic             frame_done_q;

  logic             slot_end;
  logic             frame_end;
  logic [3:0]       cur_digit;
  logic [6:0]       glyph;
  disp_s            in_payload;

  assign slot_end   = (cnt_q == CNT_W'(DIV - 1));
  assign frame_end  = slot_end && (sel_q == 2'd3);
  assign in_payload = '{digits: digits, dp: dp_mask, blink: blink_mask};
  assign cur_digit  = active_q.digits[{sel_q, 2'b00} +: 4];

  always_ff @(posedge src_clk or negedge src_rst) begin
    if (!src_rst) begin
      state_q      <= ST_BLANK;
      cnt_q        <= '0;
      sel_q        <= '0;
      blk_cnt_q    <= '0;
      phase_q      <= 1'b0;
      shadow_q     <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      an_q         <= 4'hF;
      seg_q        <= 8'hFF;
      sel_out_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      blk_cnt_q    <= blk_cnt_d;
      phase_q      <= phase_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      sel_out_q    <= sel_q;
      frame_done_q <= frame_end;
    end
  end

  // Active-low glyph for the digit currently being scanned; A-F show a dash.
  always_comb begin
    glyph = 7'h3F;
    case (cur_digit)
      4'd0: glyph = 7'h40;
      4'd1: glyph = 7'h79;
      4'd2: glyph = 7'h24;
      4'd3: glyph = 7'h30;
      4'd4: glyph = 7'h19;
      4'd5: glyph = 7'h12;
      4'd6: glyph = 7'h02;
      4'd7: glyph = 7'h78;
      4'd8: glyph = 7'h00;
      4'd9: glyph = 7'h10;
      default: glyph = 7'h3F;
    endcase
  end

  // Slot FSM and next output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    sel_d   = sel_q;
    an_d    = 4'hF;
    seg_d   = 8'hFF;

    case (state_q)
      ST_BLANK: begin
        if (slot_end) begin
          cnt_d = '0;
          sel_d = sel_q + 2'd1;
        end else if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
          state_d = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (!(blink_en && phase_q && active_q.blink[sel_q])) begin
          an_d  = ~(4'b0001 << sel_q);
          seg_d = {~active_q.dp[sel_q], glyph};
        end
        if (slot_end) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          sel_d   = sel_q + 2'd1;
        end
      end
      default: state_d = ST_BLANK;
    endcase
  end

  // Shadow capture and frame-boundary promotion; a load on the boundary bypasses the shadow.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (load) begin
      shadow_d = in_payload;
      if (frame_end) begin
        active_d  = in_payload;
        pending_d = 1'b0;
      end else begin
        pending_d = 1'b1;
      end
    end else if (frame_end && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
  end

  // Free-running blink phase, independent of the slot counter.
  always_comb begin
    blk_cnt_d = blk_cnt_q + BLK_W'(1);
    phase_d   = phase_q;
    if (blk_cnt_q == BLK_W'(HALF - 1)) begin
      blk_cnt_d = '0;
      phase_d   = ~phase_q;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign digit_sel  = sel_out_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: a time-indexed reference model
// predicts every output cycle under directed and randomized loads/blink.

module tb_seg_scan_driver;

  localparam int unsigned DIV   = 10;
  localparam int unsigned BLANK = 2;
  localparam int unsigned HALF  = 20;
  localparam int unsigned FRAME = 4 * DIV;

  logic        src_clk = 1'b0;
  logic        src_rst = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  dp_mask = '0;
  logic [3:0]  blink_mask = '0;
  logic        blink_en = 1'b0;
  logic        load = 1'b0;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic [1:0]  digit_sel;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: n counts cycles since reset release.
  int          n = 0;
  logic [15:0] m_act_dig, m_sh_dig;
  logic [3:0]  m_act_dp, m_sh_dp, m_act_bl, m_sh_bl;
  logic        m_pend;
  logic [3:0]  exp_an;
  logic [7:0]  exp_seg;
  logic [1:0]  exp_sel;
  logic        exp_fd;

  seg_scan_driver #(
    .CLK_HZ(1000), .REFRESH_HZ(100), .BLANK_CYCLES(2), .BLINK_HZ(25)
  ) dut (
    .src_clk(src_clk), .src_rst(src_rst), .digits(digits), .dp_mask(dp_mask),
    .blink_mask(blink_mask), .blink_en(blink_en), .load(load),
    .an(an), .seg(seg), .digit_sel(digit_sel), .frame_done(frame_done)
  );

  always #5 src_clk = ~src_clk;

  function automatic logic [6:0] glyph_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
      4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  task automatic model_reset();
    n = 0;
    m_act_dig = '0; m_act_dp = '0; m_act_bl = '0;
    m_sh_dig = '0;  m_sh_dp = '0;  m_sh_bl = '0;
    m_pend = 1'b0;
  endtask

  // Predict outputs for cycle n from the current inputs, advance the model, then clock.
  task automatic tick();
    int  pos, dig;
    bit  ph, boundary;
    pos = n % DIV;
    dig = (n / DIV) % 4;
    ph  = ((n / HALF) % 2) == 1;
    boundary = (n % FRAME) == FRAME - 1;
    exp_sel = 2'(dig);
    exp_fd  = boundary;
    if (pos < BLANK || (blink_en && ph && m_act_bl[dig])) begin
      exp_an  = 4'hF;
      exp_seg = 8'hFF;
    end else begin
      exp_an  = ~(4'b0001 << dig);
      exp_seg = {~m_act_dp[dig], glyph_of(m_act_dig[dig*4 +: 4])};
    end
    if (load) begin
      m_sh_dig = digits; m_sh_dp = dp_mask; m_sh_bl = blink_mask;
      if (boundary) begin
        m_act_dig = digits; m_act_dp = dp_mask; m_act_bl = blink_mask;
        m_pend = 1'b0;
      end else begin
        m_pend = 1'b1;
      end
    end else if (boundary && m_pend) begin
      m_act_dig = m_sh_dig; m_act_dp = m_sh_dp; m_act_bl = m_sh_bl;
      m_pend = 1'b0;
    end
    @(posedge src_clk);
    #1;
    n++;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({an, seg, digit_sel, frame_done} !== {4'hF, 8'hFF, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_hold: an=%h seg=%h sel=%0d fd=%b, want F FF 0 0", an, seg, digit_sel, frame_done);
    end
    @(negedge src_clk);
    src_rst = 1'b1;
    model_reset();
  endtask

  task automatic test_scan_idle();
    int fd_seen = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      n_checks++;
      if ({an, seg, digit_sel, frame_done} !== {exp_an, exp_seg, exp_sel, exp_fd}) begin
        n_fail++;
        $display("FAIL scan_idle n=%0d: an=%h/%h seg=%h/%h sel=%0d/%0d fd=%b/%b",
                 n - 1, an, exp_an, seg, exp_seg, digit_sel, exp_sel, frame_done, exp_fd);
      end
      if (frame_done) fd_seen++;
    end
    n_checks++;
    if (fd_seen !== 2) begin
      n_fail++;
      $display("FAIL frame_done_count: got %0d pulses in two frames, want 2", fd_seen);
    end
  endtask

  task automatic test_load_mid();
    logic [7:0] tbl [4];
    tbl[0] = 8'hB0; tbl[1] = 8'hF9; tbl[2] = 8'h10; tbl[3] = 8'h92;
    for (int i = 0; i < FRAME && (n % FRAME) != 15; i++) begin
      tick();
      n_checks++;
      if ({an, seg, digit_sel, frame_done} !== {exp_an, exp_seg, exp_sel, exp_fd}) begin
        n_fail++;
        $display("FAIL load_mid_pre n=%0d: an=%h/%h seg=%h/%h", n - 1, an, exp_an, seg, exp_seg);
      end
    end
    digits = 16'h5913; dp_mask = 4'b0100; blink_mask = 4'b0000; load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      n_checks++;
      if ({an, seg, digit_sel, frame_done} !== {exp_an, exp_seg, exp_sel, exp_fd}) begin
        n_fail++;
        $display("FAIL load_mid n=%0d: an=%h/%h seg=%h/%h sel=%0d/%0d fd=%b/%b",
                 n - 1, an, exp_an, seg, exp_seg, digit_sel, exp_sel, frame_done, exp_fd);
      end
      if (((n - 1) % DIV) == 5 && ((n - 1) / FRAME) == 4) begin
        n_checks++;
        if (seg !== tbl[((n - 1) / DIV) % 4]) begin
          n_fail++;
          $display("FAIL load_mid_glyph digit=%0d: seg=%h want %h", ((n - 1) / DIV) % 4, seg, tbl[((n - 1) / DIV) % 4]);
        end
      end
    end
  endtask

  task automatic test_double_load();
    digits = 16'h1111; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    digits = 16'h2222; dp_mask = 4'b0000; load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      n_checks++;
      if ({an, seg, digit_sel, frame_done} !== {exp_an, exp_seg, exp_sel, exp_fd}) begin
        n_fail++;
        $display("FAIL double_load n=%0d: an=%h/%h seg=%h/%h", n - 1, an, exp_an, seg, exp_seg);
      end
    end
  endtask

  task automatic test_load_boundary();
    digits = 16'h0000; load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < FRAME && (n % FRAME) != FRAME - 1; i++) begin
      tick();
      n_checks++;
      if ({an, seg, digit_sel, frame_done} !== {exp_an, exp_seg, exp_sel, exp_fd}) begin
        n_fail++;
        $display("FAIL boundary_pre n=%0d: an=%h/%h seg=%h/%h", n - 1, an, exp_an, seg, exp_seg);
      end
    end
    digits = 16'h4321; dp_mask = 4'b1001; load = 1'b1;
    tick();
    load = 1'b0;
    digits = 16'h7777;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      n_checks++;
      if ({an, seg, digit_sel, frame_done} !== {exp_an, exp_seg, exp_sel, exp_fd}) begin
        n_fail++;
        $display("FAIL load_boundary n=%0d: an=%h/%h seg=%h/%h", n - 1, an, exp_an, seg, exp_seg);
      end
    end
  endtask

  task automatic test_blink();
    digits = 16'h8642; dp_mask = 4'b0000; blink_mask = 4'b0001; load = 1'b1;
    tick();
    load = 1'b0;
    blink_en = 1'b1;
    for (int i = 0; i < 4 * FRAME; i++) begin
      tick();
      n_checks++;
      if ({an, seg, digit_sel, frame_done} !== {exp_an, exp_seg, exp_sel, exp_fd}) begin
        n_fail++;
        $display("FAIL blink n=%0d: an=%h/%h seg=%h/%h fd=%b/%b", n - 1, an, exp_an, seg, exp_seg, frame_done, exp_fd);
      end
    end
    blink_en = 1'b0;
  endtask

  task automatic test_dash();
    digits = 16'hBFAC; blink_mask = 4'b0000; load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      n_checks++;
      if ({an, seg, digit_sel, frame_done} !== {exp_an, exp_seg, exp_sel, exp_fd}) begin
        n_fail++;
        $display("FAIL dash n=%0d: an=%h/%h seg=%h/%h", n - 1, an, exp_an, seg, exp_seg);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 12 * FRAME; i++) begin
      load = ($urandom_range(0, 11) == 0);
      if (load) begin
        digits     = 16'($urandom);
        dp_mask    = 4'($urandom);
        blink_mask = 4'($urandom);
      end
      if ($urandom_range(0, 29) == 0) blink_en = ~blink_en;
      tick();
      n_checks++;
      if ({an, seg, digit_sel, frame_done} !== {exp_an, exp_seg, exp_sel, exp_fd}) begin
        n_fail++;
        $display("FAIL random n=%0d: an=%h/%h seg=%h/%h sel=%0d/%0d fd=%b/%b",
                 n - 1, an, exp_an, seg, exp_seg, digit_sel, exp_sel, frame_done, exp_fd);
      end
    end
    load = 1'b0;
    blink_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    digits = 16'h3456; dp_mask = 4'b1111; blink_mask = 4'b0000; load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 3 * FRAME && !((n % FRAME) == 25 && n >= FRAME); i++) begin
      tick();
      n_checks++;
      if ({an, seg, digit_sel, frame_done} !== {exp_an, exp_seg, exp_sel, exp_fd}) begin
        n_fail++;
        $display("FAIL reset_mid_pre n=%0d: an=%h/%h seg=%h/%h", n - 1, an, exp_an, seg, exp_seg);
      end
    end
    src_rst = 1'b0;
    #1;
    n_checks++;
    if ({an, seg, digit_sel, frame_done} !== {4'hF, 8'hFF, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_async: an=%h seg=%h sel=%0d fd=%b, want F FF 0 0", an, seg, digit_sel, frame_done);
    end
    @(negedge src_clk);
    src_rst = 1'b1;
    model_reset();
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      n_checks++;
      if ({an, seg, digit_sel, frame_done} !== {exp_an, exp_seg, exp_sel, exp_fd}) begin
        n_fail++;
        $display("FAIL reset_restart n=%0d: an=%h/%h seg=%h/%h sel=%0d/%0d",
                 n - 1, an, exp_an, seg, exp_seg, digit_sel, exp_sel);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_idle();
    test_load_mid();
    test_double_load();
    test_load_boundary();
    test_blink();
    test_dash();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
